if_stage: RTL and testbench



---
 rtl/if_stage.sv | 166 ++++++++++++++++
 tb/tb_if_stage.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues one outstanding word fetch at a
// time and drives the IF/ID register consumed by decode.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        control_j,
    input  logic [31:0] pc_j,
    output logic [31:0] pipe_pc,
    output logic [31:0] pipe_data,
    output logic        pipe_valid,
    output logic [31:0] fetch_count
);

    // Memory handshake: a request transfers on a cycle where imem_req && imem_ready;
    // until then imem_req/imem_addr hold steady (a redirect may retarget it).
    // imem_rvalid/imem_rdata carry the single outstanding response.
    typedef enum logic [2:0] {
        ST_START,
        ST_FETCH,
        ST_WAIT,
        ST_HOLD,
        ST_DROP
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc_reg;
    logic [31:0] req_pc;
    logic [31:0] hold_buf;
    logic        handshake;
    logic        deliver;
    logic [31:0] deliver_data;
    logic        capture_hold;

    // Fetches are word aligned, so the redirect target's byte offset is dropped.
    logic        unused_pc_j_bits;
    assign unused_pc_j_bits = ^pc_j[1:0];

    assign imem_req  = (state == ST_FETCH);
    assign imem_addr = {pc_reg[31:2], 2'b00};
    assign handshake = imem_req && imem_ready;

    always_comb begin
        deliver      = 1'b0;
        deliver_data = hold_buf;
        capture_hold = 1'b0;
        if (!control_j) begin
            if (state == ST_WAIT && imem_rvalid) begin
                if (stall) begin
                    capture_hold = 1'b1;
                end else begin
                    deliver      = 1'b1;
                    deliver_data = imem_rdata;
                end
            end else if (state == ST_HOLD && !stall) begin
                deliver = 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_START: state_next = ST_FETCH;
            ST_FETCH: begin
                if (handshake) begin
                    state_next = control_j ? ST_DROP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (control_j) begin
                    state_next = imem_rvalid ? ST_FETCH : ST_DROP;
                end else if (imem_rvalid) begin
                    state_next = stall ? ST_HOLD : ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (control_j || !stall) begin
                    state_next = ST_FETCH;
                end
            end
            // A redirect here only retargets pc_reg; the stale response still
            // has to be swallowed before a new request may go out.
            ST_DROP: begin
                if (imem_rvalid) begin
                    state_next = ST_FETCH;
                end
            end
            default: state_next = ST_START;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_START;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_reg   <= RESET_PC;
            req_pc   <= RESET_PC;
            hold_buf <= 32'h0;
        end else begin
            if (control_j) begin
                pc_reg <= {pc_j[31:2], 2'b00};
            end else if (deliver) begin
                pc_reg <= req_pc + 32'd4;
            end
            if (handshake) begin
                req_pc <= imem_addr;
            end
            if (capture_hold) begin
                hold_buf <= imem_rdata;
            end
        end
    end

    // IF/ID register: redirect flushes, stall freezes, otherwise load or bubble.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe_pc    <= 32'h0;
            pipe_data  <= NOP_INSTR;
            pipe_valid <= 1'b0;
        end else if (control_j) begin
            pipe_data  <= NOP_INSTR;
            pipe_valid <= 1'b0;
        end else if (!stall) begin
            if (deliver) begin
                pipe_pc    <= req_pc;
                pipe_data  <= deliver_data;
                pipe_valid <= 1'b1;
            end else begin
                pipe_data  <= NOP_INSTR;
                pipe_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_count <= 32'h0;
        end else if (deliver) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end

`ifndef SYNTHESIS
    a_req_stable : assert property (
        @(posedge clk) disable iff (!reset_n)
        (imem_req && !imem_ready && !control_j) |=> (imem_req && $stable(imem_addr))
    );
`endif

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: a latency-programmable instruction memory model plus a
// scoreboard of expected IF/ID entries popped on every fresh delivery.
module tb_if_stage;

    localparam logic [31:0] K   = 32'hA5A5_A5A5;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        control_j;
    logic [31:0] pc_j;
    logic [31:0] pipe_pc;
    logic [31:0] pipe_data;
    logic        pipe_valid;
    logic [31:0] fetch_count;

    logic [63:0] exp_q[$];
    int          errors = 0;
    int          checks = 0;

    // memory model state
    int          mem_lat = 1;
    int          lat_cnt = 0;
    int          hs_count = 0;
    logic [31:0] pend_addr = 32'h0;
    logic        model_rvalid = 1'b0;
    logic [31:0] model_rdata = 32'h0;
    logic        inj_rvalid = 1'b0;
    logic [31:0] inj_rdata = 32'h0;

    always #5 clk = ~clk;

    if_stage dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .control_j   (control_j),
        .pc_j        (pc_j),
        .pipe_pc     (pipe_pc),
        .pipe_data   (pipe_data),
        .pipe_valid  (pipe_valid),
        .fetch_count (fetch_count)
    );

    assign imem_rvalid = model_rvalid | inj_rvalid;
    assign imem_rdata  = inj_rvalid ? inj_rdata : model_rdata;

    // Responds mem_lat cycles after each accepted request with addr ^ K.
    always @(posedge clk) begin
        if (imem_req === 1'b1 && imem_ready === 1'b1) hs_count <= hs_count + 1;
        if (!reset_n) begin
            lat_cnt      <= 0;
            model_rvalid <= 1'b0;
        end else begin
            model_rvalid <= 1'b0;
            if (lat_cnt == 1) begin
                model_rvalid <= 1'b1;
                model_rdata  <= pend_addr ^ K;
            end
            if (lat_cnt != 0) lat_cnt <= lat_cnt - 1;
            if (imem_req === 1'b1 && imem_ready === 1'b1) begin
                pend_addr <= imem_addr;
                if (mem_lat == 1) begin
                    model_rvalid <= 1'b1;
                    model_rdata  <= imem_addr ^ K;
                end else begin
                    lat_cnt <= mem_lat - 1;
                end
            end
        end
    end

    // Advance one cycle; a valid IF/ID entry loaded while stall was low is a
    // fresh delivery and must match the head of the expected queue.
    task automatic tick();
        logic        held;
        logic [63:0] exp;
        held = stall;
        @(posedge clk);
        #1;
        if (pipe_valid === 1'b1 && !held) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got pc=%h data=%h, required no delivery", pipe_pc, pipe_data);
            end else begin
                exp = exp_q.pop_front();
                if ({pipe_pc, pipe_data} !== exp) begin
                    errors++;
                    $display("FAIL sb_entry: got pc=%h data=%h, required pc=%h data=%h",
                             pipe_pc, pipe_data, exp[63:32], exp[31:0]);
                end
            end
        end
    endtask

    task automatic push_exp(input logic [31:0] addr);
        exp_q.push_back({addr, addr ^ K});
    endtask

    task automatic test_reset();
        reset_n = 1'b0; imem_ready = 1'b0; stall = 1'b0; control_j = 1'b0; pc_j = 32'h0;
        tick(); tick();
        checks++; if (pipe_pc !== 32'h0) begin errors++; $display("FAIL rst_pipe_pc: got %h required 0", pipe_pc); end
        checks++; if (pipe_data !== NOP) begin errors++; $display("FAIL rst_pipe_data: got %h required %h", pipe_data, NOP); end
        checks++; if (pipe_valid !== 1'b0) begin errors++; $display("FAIL rst_pipe_valid: got %b required 0", pipe_valid); end
        checks++; if (fetch_count !== 32'h0) begin errors++; $display("FAIL rst_count: got %h required 0", fetch_count); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b required 0", imem_req); end
        reset_n = 1'b1;
        tick();
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL start_req: got %b required 1", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL start_addr: got %h required 0", imem_addr); end
    endtask

    task automatic test_zero_wait();
        logic want;
        for (int i = 0; i < 3; i++) push_exp(32'(i * 4));
        imem_ready = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 5) imem_ready = 1'b0;
            want = (k % 2 == 0);
            checks++;
            if (pipe_valid !== want) begin
                errors++;
                $display("FAIL zw_valid_c%0d: got %b required %b", k, pipe_valid, want);
            end
        end
        checks++; if (fetch_count !== 32'd3) begin errors++; $display("FAIL zw_count: got %0d required 3", fetch_count); end
        checks++; if (imem_addr !== 32'hC) begin errors++; $display("FAIL zw_next_addr: got %h required c", imem_addr); end
    endtask

    task automatic test_ready_low();
        int hs0;
        hs0 = hs_count;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin
                errors++;
                $display("FAIL rdy_stable_c%0d: got req=%b addr=%h required req=1 addr=c", k, imem_req, imem_addr);
            end
        end
        push_exp(32'hC);
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        tick();
        checks++; if (pipe_valid !== 1'b1) begin errors++; $display("FAIL rdy_valid: got %b required 1", pipe_valid); end
        checks++; if (fetch_count !== 32'd4) begin errors++; $display("FAIL rdy_count: got %0d required 4", fetch_count); end
        checks++; if (hs_count - hs0 != 1) begin errors++; $display("FAIL rdy_requests: got %0d required 1", hs_count - hs0); end
    endtask

    task automatic test_stall();
        int hs0;
        hs0 = hs_count;
        push_exp(32'h10);
        push_exp(32'h14);
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        tick();
        imem_ready = 1'b1;
        stall = 1'b1;
        for (int k = 3; k <= 6; k++) begin
            tick();
            if (k == 3) imem_ready = 1'b0;
            checks++;
            if (pipe_valid !== 1'b1 || pipe_pc !== 32'h10 || pipe_data !== (32'h10 ^ K)) begin
                errors++;
                $display("FAIL stall_hold_c%0d: got v=%b pc=%h data=%h required v=1 pc=10 data=%h",
                         k, pipe_valid, pipe_pc, pipe_data, 32'h10 ^ K);
            end
        end
        stall = 1'b0;
        tick();
        checks++; if (fetch_count !== 32'd6) begin errors++; $display("FAIL stall_count: got %0d required 6", fetch_count); end
        checks++; if (hs_count - hs0 != 2) begin errors++; $display("FAIL stall_requests: got %0d required 2", hs_count - hs0); end
        checks++; if (imem_addr !== 32'h18) begin errors++; $display("FAIL stall_next_addr: got %h required 18", imem_addr); end
    endtask

    task automatic test_redirect_wait();
        mem_lat = 2;
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        control_j = 1'b1;
        pc_j = 32'h0000_0103;
        tick();
        control_j = 1'b0;
        checks++; if (pipe_valid !== 1'b0) begin errors++; $display("FAIL rw_valid: got %b required 0", pipe_valid); end
        checks++; if (pipe_data !== NOP) begin errors++; $display("FAIL rw_data: got %h required %h", pipe_data, NOP); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rw_drop_req: got %b required 0", imem_req); end
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL rw_target: got req=%b addr=%h required req=1 addr=100", imem_req, imem_addr); end
        checks++; if (fetch_count !== 32'd6) begin errors++; $display("FAIL rw_discard_count: got %0d required 6", fetch_count); end
        mem_lat = 1;
        push_exp(32'h100);
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        tick();
        checks++; if (fetch_count !== 32'd7) begin errors++; $display("FAIL rw_count: got %0d required 7", fetch_count); end
    endtask

    task automatic test_redirect_hold();
        imem_ready = 1'b1;
        stall = 1'b1;
        tick();
        imem_ready = 1'b0;
        tick();
        checks++; if (pipe_valid !== 1'b1 || pipe_pc !== 32'h100) begin errors++; $display("FAIL rh_held: got v=%b pc=%h required v=1 pc=100", pipe_valid, pipe_pc); end
        control_j = 1'b1;
        pc_j = 32'h200;
        tick();
        control_j = 1'b0;
        stall = 1'b0;
        checks++; if (pipe_valid !== 1'b0 || pipe_data !== NOP) begin errors++; $display("FAIL rh_flush: got v=%b data=%h required v=0 data=%h", pipe_valid, pipe_data, NOP); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin errors++; $display("FAIL rh_target: got req=%b addr=%h required req=1 addr=200", imem_req, imem_addr); end
        push_exp(32'h200);
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        tick();
        checks++; if (fetch_count !== 32'd8) begin errors++; $display("FAIL rh_count: got %0d required 8", fetch_count); end
    endtask

    task automatic test_reset_mid();
        mem_lat = 3;
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        reset_n = 1'b0;
        #1;
        checks++; if (pipe_pc !== 32'h0 || pipe_data !== NOP || pipe_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_pipe: got pc=%h data=%h v=%b required pc=0 data=%h v=0", pipe_pc, pipe_data, pipe_valid, NOP); end
        checks++; if (fetch_count !== 32'h0) begin errors++; $display("FAIL mid_rst_count: got %0d required 0", fetch_count); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL mid_rst_req: got %b required 0", imem_req); end
        tick();
        reset_n = 1'b1;
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL mid_first_addr: got req=%b addr=%h required req=1 addr=0", imem_req, imem_addr); end
        inj_rvalid = 1'b1;
        inj_rdata = 32'hDEAD_BEEF;
        tick();
        inj_rvalid = 1'b0;
        checks++; if (pipe_valid !== 1'b0 || fetch_count !== 32'h0) begin errors++; $display("FAIL mid_late_rvalid: got v=%b count=%0d required v=0 count=0", pipe_valid, fetch_count); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL mid_still_fetch: got req=%b addr=%h required req=1 addr=0", imem_req, imem_addr); end
        mem_lat = 1;
        push_exp(32'h0);
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        tick();
        checks++; if (fetch_count !== 32'd1) begin errors++; $display("FAIL mid_restart_count: got %0d required 1", fetch_count); end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_zero_wait();
        test_ready_low();
        test_stall();
        test_redirect_wait();
        test_redirect_hold();
        test_reset_mid();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d undelivered entries, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
